mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the MIPS pipeline. Consumes the EX/MEM register contents produced by EX: res, write_register_ex, write_data_ex, m_MEM, wb_MEM and zero.
- Runs word loads and stores over a req/ack data-memory bus, stalling the pipeline while the bus is busy.
- Owns the MEM/WB pipeline register. Drives the rd_WB, wb_WB and write_data_reg signals that EX forwarding consumes.

Parameters:
- TIMEOUT, 15, max WAIT cycles without dmem_ack before the access is aborted (1..255).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high
- res  in  32  EX/MEM ALU result; data address for loads/stores
- write_data_ex  in  32  EX/MEM store data
- write_register_ex  in  5  EX/MEM destination register
- m_MEM  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
- wb_MEM  in  2  [1]=reg_write, [0]=mem_to_reg
- zero  in  1  EX/MEM ALU zero flag
- dmem_req  out  1  bus request, held until ack or abort
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  32  word address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  bus completion, 1-cycle pulse
- dmem_rdata  in  32  load data, valid with dmem_ack
- stall_mem  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- pcsrc_mem  out  1  branch taken (m_MEM[2] & zero), combinational
- wb_WB  out  2  MEM/WB control
- rd_WB  out  5  MEM/WB destination register
- read_data_wb  out  32  MEM/WB load data
- alu_res_wb  out  32  MEM/WB ALU result
- write_data_reg  out  32  wb_WB[0] ? read_data_wb : alu_res_wb, combinational
- mem_err  out  1  1-cycle pulse: misaligned access or bus timeout
- mem_err_addr  out  32  address of the last faulting access

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; timeout counter 0; dmem_req/dmem_we 0; dmem_addr/dmem_wdata 0; wb_WB 0; rd_WB 0; read_data_wb 0; alu_res_wb 0; mem_err 0; mem_err_addr 0.
- Reset mid-access: dmem_req drops immediately. Any later dmem_ack is ignored.
- mem_op = m_MEM[1] | m_MEM[0]. aligned = (res[1:0]==0). If both bits are set, treat as a store.
- IDLE, no mem_op:
  - stall_mem=0.
  - On clk edge MEM/WB loads wb_MEM, write_register_ex and res; read_data_wb holds.
- IDLE, mem_op & ~aligned:
  - stall_mem=0; no bus access.
  - MEM/WB loads a bubble (wb_WB<=0; other fields hold).
  - Next cycle: mem_err=1, mem_err_addr=res.
- IDLE, mem_op & aligned:
  - stall_mem=1.
  - MEM/WB loads a bubble.
  - Register dmem_addr=res, dmem_we=m_MEM[0], dmem_wdata=write_data_ex; counter<=0; go to WAIT.
- WAIT:
  - dmem_req=1; stall_mem=1; MEM/WB loads a bubble each cycle; counter increments.
  - dmem_ack=1: capture dmem_rdata into an internal holding register; dmem_req<=0; go to DONE.
  - ack absent and counter==TIMEOUT-1: dmem_req<=0, mark aborted, go to DONE.
  - ack in the same cycle as the timeout expiry: ack wins.
- DONE:
  - stall_mem=0.
  - On clk edge MEM/WB loads wb_MEM, write_register_ex, res and the held read data. EX/MEM advances on that same edge. Go to IDLE.
  - If aborted: wb_WB<=0 and mem_err pulses next cycle with mem_err_addr=dmem_addr.
  - The instruction still in EX/MEM during DONE is never re-issued.
- dmem_ack seen in IDLE or DONE is ignored.
- Store write-back: reg_write is normally 0 for stores; the block passes wb_MEM through unmodified.
- Latency: minimum stall is 2 cycles (IDLE + 1 WAIT) for ack in the first WAIT cycle. The load result is visible on write_data_reg 3 cycles after the op first appears in EX/MEM.
- pcsrc_mem is purely combinational and independent of the state machine.

Test Plan:
- ALU op, wb_MEM=2'b10, res=0x1234, rd=5 -> next cycle wb_WB=2'b10, rd_WB=5, write_data_reg=0x1234; stall_mem never 1.
- Load, res=0x100, ack 1 cycle after req with rdata=0xDEADBEEF, wb_MEM=2'b11, rd=8 -> stall_mem high 2 cycles; dmem_addr=0x100, dmem_we=0; then wb_WB=2'b11, rd_WB=8, write_data_reg=0xDEADBEEF.
- Store, res=0x40, write_data_ex=0xCAFE0001, ack after 4 WAIT cycles -> dmem_req high exactly 4 cycles, dmem_we=1, dmem_wdata=0xCAFE0001; stall_mem high 5 cycles.
- Load at res=0x102 -> no dmem_req, stall_mem=0, wb_WB=0 next cycle, mem_err pulse with mem_err_addr=0x102.
- Load with no ack, TIMEOUT=15 -> dmem_req high 15 cycles then low; mem_err pulse, mem_err_addr=load address; wb_WB=0; a late ack 3 cycles afterwards is ignored.
- rst asserted during WAIT -> dmem_req and stall_mem drop in the same cycle; state IDLE; all outputs 0. Also: branch=1, zero=1 -> pcsrc_mem=1 combinationally.

Source files
------------

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Data-memory request/acknowledge bus used by the MEM stage.
//                master: pipeline side (drives request, address, data, we)
//                slave : memory side   (drives ack and read data)
//  Signals     : dmem_req   - request, held until ack or abort
//                dmem_we    - 1 = store, 0 = load
//                dmem_addr  - word address
//                dmem_wdata - store data
//                dmem_ack   - one-cycle completion pulse
//                dmem_rdata - load data, valid with dmem_ack
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MIPS memory stage. Performs word loads/stores over a
//                req/ack data bus, stalls the pipeline while the bus is
//                busy, and owns the MEM/WB pipeline register.
//  Ports       : clk, rst            - clock, async active-high reset
//                res, write_data_ex, write_register_ex, m_MEM, wb_MEM, zero
//                                    - EX/MEM register contents
//                dmem                - data-memory bus (master side)
//                stall_mem           - freeze earlier pipeline stages
//                pcsrc_mem           - branch taken
//                wb_WB, rd_WB, read_data_wb, alu_res_wb - MEM/WB register
//                write_data_reg      - write-back value (for forwarding)
//                mem_err, mem_err_addr - misalignment / bus timeout report
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] res,
    input  wire logic [31:0] write_data_ex,
    input  wire logic [4:0]  write_register_ex,
    input  wire logic [2:0]  m_MEM,
    input  wire logic [1:0]  wb_MEM,
    input  wire logic        zero,
    mem_stage_if.master      dmem,
    output logic             stall_mem,
    output logic             pcsrc_mem,
    output logic [1:0]       wb_WB,
    output logic [4:0]       rd_WB,
    output logic [31:0]      read_data_wb,
    output logic [31:0]      alu_res_wb,
    output logic [31:0]      write_data_reg,
    output logic             mem_err,
    output logic [31:0]      mem_err_addr
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_WAIT = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    // Last WAIT count value before the access is abandoned.
    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,      state_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic        aborted_q,    aborted_d;
    logic [31:0] hold_q,       hold_d;
    logic        req_q,        req_d;
    logic        we_q,         we_d;
    logic [31:0] addr_q,       addr_d;
    logic [31:0] wdata_q,      wdata_d;
    logic [1:0]  wb_wb_q,      wb_wb_d;
    logic [4:0]  rd_wb_q,      rd_wb_d;
    logic [31:0] rdata_wb_q,   rdata_wb_d;
    logic [31:0] alu_wb_q,     alu_wb_d;
    logic        err_q,        err_d;
    logic [31:0] err_addr_q,   err_addr_d;

    logic w_mem_op;
    logic w_aligned;
    logic w_stall;

    assign w_mem_op  = m_MEM[1] | m_MEM[0];
    assign w_aligned = (res[1:0] == 2'b00);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        aborted_d  = aborted_q;
        hold_d     = hold_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_wb_d    = wb_wb_q;
        rd_wb_d    = rd_wb_q;
        rdata_wb_d = rdata_wb_q;
        alu_wb_d   = alu_wb_q;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        w_stall    = 1'b0;

        case (state_q)
            C_IDLE: begin
                if (!w_mem_op) begin
                    wb_wb_d  = wb_MEM;
                    rd_wb_d  = write_register_ex;
                    alu_wb_d = res;
                end else if (!w_aligned) begin
                    // Faulting access: squash write-back, no bus cycle.
                    wb_wb_d    = 2'b00;
                    err_d      = 1'b1;
                    err_addr_d = res;
                end else begin
                    w_stall   = 1'b1;
                    wb_wb_d   = 2'b00;
                    addr_d    = res;
                    we_d      = m_MEM[0];   // both bits set -> store
                    wdata_d   = write_data_ex;
                    cnt_d     = 8'd0;
                    aborted_d = 1'b0;
                    req_d     = 1'b1;
                    state_d   = C_WAIT;
                end
            end
            C_WAIT: begin
                w_stall = 1'b1;
                wb_wb_d = 2'b00;
                cnt_d   = cnt_q + 8'd1;
                // Ack takes priority over a coincident timeout.
                if (dmem.dmem_ack) begin
                    hold_d  = dmem.dmem_rdata;
                    req_d   = 1'b0;
                    state_d = C_DONE;
                end else if (cnt_q == C_CNT_LAST) begin
                    req_d     = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = C_DONE;
                end
            end
            C_DONE: begin
                // EX/MEM advances on this edge, so the op is retired here
                // and never seen again in IDLE.
                wb_wb_d    = aborted_q ? 2'b00 : wb_MEM;
                rd_wb_d    = write_register_ex;
                alu_wb_d   = res;
                rdata_wb_d = hold_q;
                if (aborted_q) begin
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                end
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= C_IDLE;
            cnt_q      <= 8'd0;
            aborted_q  <= 1'b0;
            hold_q     <= 32'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wb_wb_q    <= 2'b00;
            rd_wb_q    <= 5'd0;
            rdata_wb_q <= 32'd0;
            alu_wb_q   <= 32'd0;
            err_q      <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            aborted_q  <= aborted_d;
            hold_q     <= hold_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_wb_q    <= wb_wb_d;
            rd_wb_q    <= rd_wb_d;
            rdata_wb_q <= rdata_wb_d;
            alu_wb_q   <= alu_wb_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    // Reset must release the pipeline at once, even with a memory op in EX/MEM.
    assign stall_mem      = w_stall & ~rst;
    assign pcsrc_mem      = m_MEM[2] & zero;
    assign wb_WB          = wb_wb_q;
    assign rd_WB          = rd_wb_q;
    assign read_data_wb   = rdata_wb_q;
    assign alu_res_wb     = alu_wb_q;
    assign write_data_reg = wb_wb_q[0] ? rdata_wb_q : alu_wb_q;
    assign mem_err        = err_q;
    assign mem_err_addr   = err_addr_q;

endmodule
`default_nettype wire
